// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversal reorder buffer for a radix-2 SDF FFT output stream.
// The input arrives in bit-reversed index order and leaves in natural order,
// with ping-pong banks for one sample per cycle sustained throughput.
// Optional feature: define FFT_REORDER_ERR_EN to add the sticky frame-alignment
// error output err.
module fft_reorder #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic         in_start,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_start,
   output logic         out_last
`ifdef FFT_REORDER_ERR_EN
   ,
   output logic         err
`endif
);

   localparam int unsigned DEPTH = 32'(1) << N;
   localparam int unsigned DW    = 2 * W;
   localparam logic [N-1:0] LAST_IDX = N'(DEPTH - 1);

   logic [DW-1:0] mem [2][DEPTH];
   logic [1:0]    full;
   logic          wr_bank;
   logic          rd_bank;
   logic [N-1:0]  wr_cnt;
   logic [N-1:0]  rd_cnt;

   logic          wr_en;
   logic          wr_last;
   logic [N-1:0]  wr_addr;
   logic          rd_load;
   logic          rd_last;
   logic [DW-1:0] rd_word;

   function automatic logic [N-1:0] bitrev(input logic [N-1:0] x);
      logic [N-1:0] r;
      for (int i = 0; i < int'(N); i++) r[i] = x[N-1-i];
      return r;
   endfunction

   // Handshake decode and addressing for both sides of the buffer
   always_comb begin
      in_ready = !full[wr_bank];
      wr_en    = in_valid && in_ready;
      wr_last  = wr_en && !in_start && (wr_cnt == LAST_IDX);
      wr_addr  = in_start ? '0 : bitrev(wr_cnt);
      rd_load  = full[rd_bank] && (!out_valid || out_ready);
      rd_last  = rd_load && (rd_cnt == LAST_IDX);
      rd_word  = mem[rd_bank][rd_cnt];
   end

   // Sample storage; contents need no reset since full flags gate every read
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= {in_re, in_im};
   end

   // Write counter and bank select; in_start restarts the frame at element 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_en) begin
         if (in_start) begin
            wr_cnt <= N'(1);
         end else begin
            wr_cnt <= wr_cnt + N'(1);
            if (wr_last) wr_bank <= ~wr_bank;
         end
      end
   end

   // Bank full flags: set by the writer, cleared by the reader, never the same bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_last && (wr_bank == 1'(b)))      full[b] <= 1'b1;
            else if (rd_last && (rd_bank == 1'(b))) full[b] <= 1'b0;
         end
      end
   end

   // Read counter, bank select and registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_start <= 1'b0;
         out_last  <= 1'b0;
      end else if (rd_load) begin
         out_re    <= rd_word[DW-1:W];
         out_im    <= rd_word[W-1:0];
         out_start <= (rd_cnt == '0);
         out_last  <= (rd_cnt == LAST_IDX);
         out_valid <= 1'b1;
         rd_cnt    <= rd_cnt + N'(1);
         if (rd_last) rd_bank <= ~rd_bank;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef FFT_REORDER_ERR_EN
   // Sticky alignment error: start mid-frame, or a frame that begins without start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (wr_en && ((in_start && (wr_cnt != '0)) ||
                             (!in_start && (wr_cnt == '0)))) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Testbench for fft_reorder: directed scenarios with random sample data,
// checked against a frame-level reorder model (output position = bitrev(input index)).
module tb_fft_reorder;

   localparam int unsigned N = 4;
   localparam int unsigned W = 16;
   localparam int unsigned L = 32'(1) << N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid, in_start, in_ready;
   logic [W-1:0] in_re, in_im;
   logic         out_valid, out_ready, out_start, out_last;
   logic [W-1:0] out_re, out_im;
`ifdef FFT_REORDER_ERR_EN
   logic         err;
`endif

   always #5 clk = ~clk;

   fft_reorder #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_start(in_start), .in_re(in_re), .in_im(in_im),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_start(out_start), .out_last(out_last)
`ifdef FFT_REORDER_ERR_EN
      , .err(err)
`endif
   );

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic         st;
      logic         la;
   } smp_t;

   smp_t           exp_q[$];
   logic [2*W-1:0] part[L];
   int             pcnt = 0;
   logic           err_exp = 1'b0;
   int             checks = 0;
   int             errors = 0;
   int             run = 0;
   int             max_run = 0;
   int             stalls = 0;
   logic [W-1:0]   seen_re[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int i = 0; i < int'(N); i++) r = r * 2 + ((k >> i) & 1);
      return r;
   endfunction

   // Frame model: collect a frame in arrival order, emit element k at position bitrev(k)
   task automatic model_accept(input logic s, input logic [W-1:0] re, input logic [W-1:0] im);
      smp_t f[L];
      if ((s && pcnt != 0) || (!s && pcnt == 0)) err_exp = 1'b1;
      if (s) pcnt = 0;
      part[pcnt] = {re, im};
      pcnt++;
      if (pcnt == int'(L)) begin
         for (int k = 0; k < int'(L); k++) begin
            f[brev(k)] = '{re: part[k][2*W-1:W], im: part[k][W-1:0],
                           st: (brev(k) == 0), la: (brev(k) == int'(L) - 1)};
         end
         for (int p = 0; p < int'(L); p++) exp_q.push_back(f[p]);
         pcnt = 0;
      end
   endtask

   // One clock cycle: drive at negedge, sample 1 time unit later, then advance
   task automatic step(input logic v, input logic s, input logic [W-1:0] re,
                       input logic [W-1:0] im, input logic ordy, output logic acc);
      smp_t got, want;
      in_valid = v; in_start = s; in_re = re; in_im = im; out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (v && !in_ready) stalls++;
      if (out_valid) begin
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (out_valid && ordy) begin
         got = '{re: out_re, im: out_im, st: out_start, la: out_last};
         seen_re.push_back(out_re);
         check("output_expected", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("out_sample", 64'(got), 64'(want));
         end
      end
`ifdef FFT_REORDER_ERR_EN
      check("err", 64'(err), 64'(err_exp));
`endif
      if (acc) model_accept(s, re, im);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input int i0, input int n, input logic ordy, input bit idx);
      logic acc;
      logic [W-1:0] re, im;
      int g;
      for (int i = i0; i < i0 + n; i++) begin
         re = idx ? W'(i % int'(L)) : W'($urandom);
         im = W'($urandom);
         acc = 1'b0;
         g = 0;
         while (!acc && g < 200) begin
            step(1'b1, 1'((i % int'(L)) == 0), re, im, ordy, acc);
            g++;
         end
         check("send_accepted", 64'(acc), 64'(1));
      end
   endtask

   task automatic drain();
      logic a;
      int g = 0;
      while (exp_q.size() > 0 && g < 400) begin
         step(1'b0, 1'b0, '0, '0, 1'b1, a);
         g++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      step(1'b0, 1'b0, '0, '0, 1'b1, a);
      check("out_valid_idle", 64'(out_valid), 64'(0));
   endtask

   initial begin
      int tbl[16];
      logic a;
      logic [W-1:0] hold_re, hold_im;
      tbl = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      in_valid = 1'b0; in_start = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_re", 64'(out_re), 64'(0));
      check("rst_out_start", 64'(out_start), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame with in_re = k
      seen_re.delete();
      send(0, 16, 1'b1, 1'b1);
      check("latency_not_yet", 64'(out_valid), 64'(0));
      step(1'b0, 1'b0, '0, '0, 1'b0, a);
      check("latency_valid", 64'(out_valid), 64'(1));
      check("latency_start", 64'(out_start), 64'(1));
      drain();
      check("single_count", 64'(seen_re.size()), 64'(16));
      for (int i = 0; i < 16 && i < seen_re.size(); i++)
         check("single_order", 64'(seen_re[i]), 64'(tbl[i]));

      // Four frames back to back
      stalls = 0; max_run = 0; run = 0;
      send(0, 64, 1'b1, 1'b0);
      drain();
      check("b2b_no_stall", 64'(stalls), 64'(0));
      check("b2b_valid_run", 64'(max_run), 64'(64));

      // Backpressure: two frames fill both banks, third waits
      seen_re.delete();
      send(0, 32, 1'b0, 1'b0);
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      hold_re = out_re; hold_im = out_im;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, '0, '0, 1'b0, a);
         check("bp_hold_re", 64'(out_re), 64'(hold_re));
         check("bp_hold_im", 64'(out_im), 64'(hold_im));
         check("bp_hold_start", 64'(out_start), 64'(1));
         check("bp_hold_ready", 64'(in_ready), 64'(0));
      end
      send(32, 16, 1'b1, 1'b0);
      drain();
      check("bp_count", 64'(seen_re.size()), 64'(48));

      // Misaligned start: restart after 5 samples, frame completes 16 after it
      send(0, 5, 1'b1, 1'b0);
      send(0, 15, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, a);
      check("mis_no_output", 64'(out_valid), 64'(0));
      send(15, 1, 1'b1, 1'b0);
      drain();
`ifdef FFT_REORDER_ERR_EN
      check("mis_err_sticky", 64'(err), 64'(1));
`endif

      // Reset in the middle of the second frame
      send(0, 24, 1'b0, 1'b0);
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'(0));
      check("arst_out_re", 64'(out_re), 64'(0));
      check("arst_out_im", 64'(out_im), 64'(0));
      check("arst_out_start", 64'(out_start), 64'(0));
      check("arst_in_ready", 64'(in_ready), 64'(1));
`ifdef FFT_REORDER_ERR_EN
      check("arst_err", 64'(err), 64'(0));
`endif
      exp_q.delete();
      pcnt = 0;
      err_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 16, 1'b1, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
